// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard controller and its forwarding units.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [4:0] ALU_NOP = 5'd0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational operand forwarding select for one ID source operand.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_we_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_we_i,
  input  logic              kill_i,
  output fwd_sel_t          sel_o
);

  logic ex_hit;
  logic mem_hit;

  // A load result is not available in EX, so it is never a forwarding source.
  assign ex_hit  = ex_we_i & ~ex_is_load_i & (ex_rd_i != '0) & (ex_rd_i == rs_i);
  assign mem_hit = mem_we_i & (mem_rd_i != '0) & (mem_rd_i == rs_i);

  always_comb begin
    sel_o = FWD_RF;
    if (!kill_i) begin
      if (ex_hit) begin
        sel_o = FWD_EX;
      end else if (mem_hit) begin
        sel_o = FWD_MEM;
      end
    end
  end

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX pipeline sequencing: load-use stalls, redirect flushes, operand forwarding selects.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module id_ex_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW            = 5,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 2
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W             = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ID_rs_a,
  input  logic [REG_AW-1:0] ID_rs_b,
  input  logic              ID_uses_a,
  input  logic              ID_uses_b,
  input  logic [REG_AW-1:0] EX_rd,
  input  logic              EX_RF_WE,
  input  logic              EX_is_load,
  input  logic [REG_AW-1:0] MEM_rd,
  input  logic              MEM_RF_WE,
  input  logic              EX_ret_enable,
  input  logic              EX_branch_taken,
  output logic              IF_stall,
  output logic              ID_EX_bubble,
  output logic              IF_ID_flush,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
`endif
);

  localparam int unsigned CNT_MAX = max_u(LOAD_STALL_CYCLES, FLUSH_CYCLES);
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

  // cnt holds the bubbles still owed after the current one, minus one.
  localparam logic [CW-1:0] STALL_RELOAD = (LOAD_STALL_CYCLES > 1) ? CW'(LOAD_STALL_CYCLES - 2) : '0;
  localparam logic [CW-1:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? CW'(FLUSH_CYCLES - 2) : '0;

  hz_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic     hz_lu;
  logic     redir;
  logic     stall_raw;
  logic     flush_raw;
  logic     kill;
  fwd_sel_t sel_a;
  fwd_sel_t sel_b;

  assign hz_lu = EX_is_load & EX_RF_WE & (EX_rd != '0)
               & ((ID_uses_a & (ID_rs_a == EX_rd)) | (ID_uses_b & (ID_rs_b == EX_rd)));
  assign redir = EX_ret_enable | EX_branch_taken;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    flush_raw = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redir) begin
          flush_raw = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (hz_lu) begin
          stall_raw = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = STALL;
            cnt_d   = STALL_RELOAD;
          end
        end
      end
      STALL: begin
        if (redir) begin
          // Redirect wins: the stalled instruction is on the wrong path anyway.
          flush_raw = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end else begin
            state_d = RUN;
          end
        end else begin
          stall_raw = 1'b1;
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      FLUSH: begin
        flush_raw = 1'b1;
        if (redir) begin
          if (FLUSH_CYCLES > 1) begin
            cnt_d = FLUSH_RELOAD;
          end else begin
            state_d = RUN;
          end
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign IF_stall     = stall_raw & ~rst;
  assign IF_ID_flush  = flush_raw & ~rst;
  assign ID_EX_bubble = (stall_raw | flush_raw) & ~rst;
  assign busy         = (state_q != RUN) & ~rst;
  assign kill         = ID_EX_bubble | rst;

  fwd_unit #(
    .REG_AW(REG_AW)
  ) u_fwd_a (
    .rs_i        (ID_rs_a),
    .ex_rd_i     (EX_rd),
    .ex_we_i     (EX_RF_WE),
    .ex_is_load_i(EX_is_load),
    .mem_rd_i    (MEM_rd),
    .mem_we_i    (MEM_RF_WE),
    .kill_i      (kill),
    .sel_o       (sel_a)
  );

  fwd_unit #(
    .REG_AW(REG_AW)
  ) u_fwd_b (
    .rs_i        (ID_rs_b),
    .ex_rd_i     (EX_rd),
    .ex_we_i     (EX_RF_WE),
    .ex_is_load_i(EX_is_load),
    .mem_rd_i    (MEM_rd),
    .mem_we_i    (MEM_RF_WE),
    .kill_i      (kill),
    .sel_o       (sel_b)
  );

  assign fwd_sel_a = sel_a;
  assign fwd_sel_b = sel_b;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (IF_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (IF_ID_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Bench for id_ex_hazard_ctrl: two instances (1/2 and 3/3 stall/flush cycles) against a
// bubble-budget reference model; perf counters are checked when HAZARD_PERF_CNT_EN is defined.
module tb_id_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs_a, rs_b, ex_rd, mem_rd;
  logic       ua, ub, ex_we, ex_ld, mem_we, ret, br;

  logic       st [2];
  logic       bb [2];
  logic       fl [2];
  logic       bz [2];
  logic [1:0] fa [2];
  logic [1:0] fb [2];
  logic [7:0] obs [2];

  int checks = 0;
  int errors = 0;

  // Model state: bubbles still owed after the current cycle.
  int m_stall [2];
  int m_flush [2];

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] sc0, fc0;
  logic [1:0]  sc1, fc1;
  int m_sc [2];
  int m_fc [2];
`endif

  always #5 clk = ~clk;

  id_ex_hazard_ctrl #(
    .REG_AW(5),
    .LOAD_STALL_CYCLES(1),
    .FLUSH_CYCLES(2)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_W(16)
`endif
  ) dut0 (
    .clk(clk), .rst(rst),
    .ID_rs_a(rs_a), .ID_rs_b(rs_b), .ID_uses_a(ua), .ID_uses_b(ub),
    .EX_rd(ex_rd), .EX_RF_WE(ex_we), .EX_is_load(ex_ld),
    .MEM_rd(mem_rd), .MEM_RF_WE(mem_we),
    .EX_ret_enable(ret), .EX_branch_taken(br),
    .IF_stall(st[0]), .ID_EX_bubble(bb[0]), .IF_ID_flush(fl[0]),
    .fwd_sel_a(fa[0]), .fwd_sel_b(fb[0]), .busy(bz[0])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(sc0), .flush_count(fc0)
`endif
  );

  id_ex_hazard_ctrl #(
    .REG_AW(5),
    .LOAD_STALL_CYCLES(3),
    .FLUSH_CYCLES(3)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_W(2)
`endif
  ) dut1 (
    .clk(clk), .rst(rst),
    .ID_rs_a(rs_a), .ID_rs_b(rs_b), .ID_uses_a(ua), .ID_uses_b(ub),
    .EX_rd(ex_rd), .EX_RF_WE(ex_we), .EX_is_load(ex_ld),
    .MEM_rd(mem_rd), .MEM_RF_WE(mem_we),
    .EX_ret_enable(ret), .EX_branch_taken(br),
    .IF_stall(st[1]), .ID_EX_bubble(bb[1]), .IF_ID_flush(fl[1]),
    .fwd_sel_a(fa[1]), .fwd_sel_b(fb[1]), .busy(bz[1])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(sc1), .flush_count(fc1)
`endif
  );

  for (genvar g = 0; g < 2; g++) begin : g_obs
    assign obs[g] = {st[g], bb[g], fl[g], fa[g], fb[g], bz[g]};
  end

  function automatic int lsc(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int fcy(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic bit hz_ref();
    return ex_ld && ex_we && (ex_rd != 0) &&
           ((ua && rs_a == ex_rd) || (ub && rs_b == ex_rd));
  endfunction

  function automatic bit redir_ref();
    return ret || br;
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (ex_we && !ex_ld && ex_rd != 0 && ex_rd == rs) return 2'b01;
    if (mem_we && mem_rd != 0 && mem_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Expected {stall, bubble, flush, fwd_a, fwd_b, busy} for instance k this cycle.
  function automatic logic [7:0] predict(input int k);
    logic s, f, b, y;
    logic [1:0] xa, xb;
    if (rst) return 8'h00;
    s = 1'b0;
    f = 1'b0;
    y = (m_flush[k] > 0) || (m_stall[k] > 0);
    if (m_flush[k] > 0 || redir_ref()) f = 1'b1;
    else if (m_stall[k] > 0 || hz_ref()) s = 1'b1;
    b  = s | f;
    xa = b ? 2'b00 : fwd_ref(rs_a);
    xb = b ? 2'b00 : fwd_ref(rs_b);
    return {s, b, f, xa, xb, y};
  endfunction

  task automatic step();
`ifdef HAZARD_PERF_CNT_EN
    logic [7:0] e [2];
    for (int k = 0; k < 2; k++) e[k] = predict(k);
`endif
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_stall[k] = 0;
        m_flush[k] = 0;
`ifdef HAZARD_PERF_CNT_EN
        m_sc[k] = 0;
        m_fc[k] = 0;
`endif
      end else begin
`ifdef HAZARD_PERF_CNT_EN
        if (e[k][7] && m_sc[k] < ((k == 0) ? 65535 : 3)) m_sc[k]++;
        if (e[k][5] && m_fc[k] < ((k == 0) ? 65535 : 3)) m_fc[k]++;
`endif
        if (m_flush[k] > 0) begin
          m_flush[k] = redir_ref() ? fcy(k) - 1 : m_flush[k] - 1;
        end else if (redir_ref()) begin
          m_flush[k] = fcy(k) - 1;
          m_stall[k] = 0;
        end else if (m_stall[k] > 0) begin
          m_stall[k] = m_stall[k] - 1;
        end else if (hz_ref()) begin
          m_stall[k] = lsc(k) - 1;
        end
      end
    end
    #1;
  endtask

  task automatic clear_in();
    rs_a = '0; rs_b = '0; ex_rd = '0; mem_rd = '0;
    ua = 0; ub = 0; ex_we = 0; ex_ld = 0; mem_we = 0; ret = 0; br = 0;
  endtask

  task automatic test_reset();
    rs_a = 5'd3; rs_b = 5'd3; ex_rd = 5'd3; mem_rd = 5'd3;
    ua = 1; ub = 1; ex_we = 1; ex_ld = 1; mem_we = 1; ret = 1; br = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== 8'h00) begin
          errors++;
          $display("FAIL reset_outputs c%0d dut%0d got %b want 00000000", c, k, obs[k]);
        end
      end
      step();
    end
    rst = 0;
    clear_in();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== predict(k)) begin
        errors++;
        $display("FAIL reset_release dut%0d got %b want %b", k, obs[k], predict(k));
      end
    end
    step();
  endtask

  task automatic test_load_use();
    int nst [2];
    int nbz [2];
    nst = '{0, 0};
    nbz = '{0, 0};
    clear_in();
    ex_ld = 1; ex_we = 1; ex_rd = 5'd5; rs_a = 5'd5; ua = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== predict(k)) begin
          errors++;
          $display("FAIL load_use c%0d dut%0d got %b want %b", c, k, obs[k], predict(k));
        end
        nst[k] += int'(st[k]);
        nbz[k] += int'(bz[k]);
      end
      step();
      clear_in();
    end
    checks++;
    if (nst[0] !== 1) begin
      errors++;
      $display("FAIL load_use_len1 stall cycles got %0d want 1", nst[0]);
    end
    checks++;
    if (nst[1] !== 3 || nbz[1] !== 2) begin
      errors++;
      $display("FAIL load_use_len3 stall/busy cycles got %0d/%0d want 3/2", nst[1], nbz[1]);
    end
  endtask

  task automatic test_redirect();
    int nfl [2];
    int nst;
    nfl = '{0, 0};
    nst = 0;
    clear_in();
    br = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== predict(k)) begin
          errors++;
          $display("FAIL redirect c%0d dut%0d got %b want %b", c, k, obs[k], predict(k));
        end
        nfl[k] += int'(fl[k]);
        nst += int'(st[k]);
      end
      step();
      clear_in();
    end
    checks++;
    if (nfl[0] !== 2 || nfl[1] !== 3 || nst !== 0 || bz[0] !== 1'b0) begin
      errors++;
      $display("FAIL redirect_len flush %0d/%0d stall %0d busy %b want 2/3 0 0",
               nfl[0], nfl[1], nst, bz[0]);
    end
  endtask

  task automatic test_simultaneous();
    clear_in();
    ex_ld = 1; ex_we = 1; ex_rd = 5'd9; rs_b = 5'd9; ub = 1; ret = 1;
    #1;
    checks++;
    if (st[0] !== 1'b0 || fl[0] !== 1'b1 || st[1] !== 1'b0 || fl[1] !== 1'b1) begin
      errors++;
      $display("FAIL hz_and_ret stall %b%b flush %b%b want 00 11", st[0], st[1], fl[0], fl[1]);
    end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== predict(k)) begin
          errors++;
          $display("FAIL simul_a c%0d dut%0d got %b want %b", c, k, obs[k], predict(k));
        end
      end
      step();
      clear_in();
    end
    // Load-use into STALL on dut1, then a return during its second stall cycle.
    ex_ld = 1; ex_we = 1; ex_rd = 5'd4; rs_a = 5'd4; ua = 1;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) clear_in();
      if (c == 1) ret = 1;
      #1;
      if (c == 1) begin
        checks++;
        if (st[1] !== 1'b0 || fl[1] !== 1'b1 || bb[1] !== 1'b1) begin
          errors++;
          $display("FAIL ret_in_stall stall %b flush %b bubble %b want 0 1 1", st[1], fl[1], bb[1]);
        end
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== predict(k)) begin
          errors++;
          $display("FAIL simul_b c%0d dut%0d got %b want %b", c, k, obs[k], predict(k));
        end
      end
      step();
      clear_in();
    end
  endtask

  task automatic test_forwarding();
    logic [1:0] want [4];
    want = '{2'b01, 2'b10, 2'b00, 2'b00};
    for (int p = 0; p < 4; p++) begin
      clear_in();
      ex_rd = 5'd7; mem_rd = 5'd7; ex_we = 1; mem_we = 1; rs_b = 5'd7; ub = 1;
      if (p == 1) ex_we = 0;
      if (p == 2) begin ex_rd = 5'd0; mem_rd = 5'd0; rs_b = 5'd0; end
      if (p == 3) ex_ld = 1;
      #1;
      checks++;
      if (fb[0] !== want[p] || (p == 3 && st[0] !== 1'b1)) begin
        errors++;
        $display("FAIL fwd_b pattern%0d got %b stall %b want %b", p, fb[0], st[0], want[p]);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== predict(k)) begin
          errors++;
          $display("FAIL fwd_model p%0d dut%0d got %b want %b", p, k, obs[k], predict(k));
        end
      end
      step();
    end
    clear_in();
    for (int c = 0; c < 4; c++) step();
    for (int k = 0; k < 2; k++) begin
      m_stall[k] = m_stall[k];
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rs_a   = 5'($urandom_range(0, 3));
      rs_b   = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3));
      ua     = 1'($urandom);
      ub     = 1'($urandom);
      ex_we  = 1'($urandom);
      ex_ld  = 1'($urandom);
      mem_we = 1'($urandom);
      ret    = ($urandom_range(0, 11) == 0);
      br     = ($urandom_range(0, 9) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== predict(k)) begin
          errors++;
          $display("FAIL random c%0d dut%0d got %b want %b", c, k, obs[k], predict(k));
        end
      end
      step();
    end
    clear_in();
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_reset_mid_flush();
    clear_in();
    br = 1;
    step();
    clear_in();
    #1;
    checks++;
    if (bz[0] !== 1'b1 || fl[0] !== 1'b1 || bz[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_flush_entry busy %b%b flush %b want 11 1", bz[0], bz[1], fl[0]);
    end
    #1;
    rst = 1;
    m_stall = '{0, 0};
    m_flush = '{0, 0};
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 8'h00) begin
        errors++;
        $display("FAIL async_reset dut%0d got %b want 00000000", k, obs[k]);
      end
    end
    step();
    #3;
    rst = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bz[k] !== 1'b0 || obs[k] !== predict(k)) begin
        errors++;
        $display("FAIL after_reset dut%0d got %b want %b", k, obs[k], predict(k));
      end
    end
    step();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    clear_in();
    #2;
    rst = 1;
    step();
    rst = 0;
    step();
    ex_ld = 1; ex_we = 1; ex_rd = 5'd6; rs_a = 5'd6; ua = 1;
    for (int c = 0; c < 4; c++) step();
    clear_in();
    for (int c = 0; c < 3; c++) step();
    br = 1;
    step();
    clear_in();
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (int'(sc0) !== 4 || int'(fc0) !== 2) begin
      errors++;
      $display("FAIL perf_counts got %0d/%0d want 4/2", sc0, fc0);
    end
    checks++;
    if (int'(sc1) !== m_sc[1] || int'(fc1) !== m_fc[1] || sc1 !== 2'b11) begin
      errors++;
      $display("FAIL perf_saturate got %0d/%0d want %0d/%0d", sc1, fc1, m_sc[1], m_fc[1]);
    end
  endtask
`endif

  initial begin
    m_stall = '{0, 0};
    m_flush = '{0, 0};
`ifdef HAZARD_PERF_CNT_EN
    m_sc = '{0, 0};
    m_fc = '{0, 0};
`endif
    clear_in();
    #1;
    test_reset();
    test_load_use();
    test_redirect();
    test_simultaneous();
    test_forwarding();
    test_random();
    test_reset_mid_flush();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
